// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns 1/2/4-byte fetch/load/store requests
// into 8-bit bus cycles and reassembles read results little-endian.
module mem_ctrl #(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              inst_valid,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic [31:0]       inst_res,
  input  logic              data_valid,
  input  logic              data_wr,
  input  logic [2:0]        data_type,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_value,
  output logic              data_ready,
  output logic [31:0]       data_res,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              is_inst_q, is_inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       val_q, val_d;
  logic [31:0]       res_q, res_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              inst_ready_q, inst_ready_d;
  logic              data_ready_q, data_ready_d;
  logic [31:0]       inst_res_q, inst_res_d;
  logic [31:0]       data_res_q, data_res_d;

  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       res_nxt;
  logic [2:0]        rd_idx;
  logic              io_blk;
  logic              unused_type_bit;

  assign unused_type_bit = data_type[2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    is_inst_d    = is_inst_q;
    addr_d       = addr_q;
    val_d        = val_q;
    res_d        = res_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    inst_res_d   = inst_res_q;
    data_res_d   = data_res_q;
    acc_addr     = data_valid ? data_addr : inst_addr;
    res_nxt      = res_q;
    rd_idx       = cnt_q - 3'd1;
    io_blk       = (addr_q[17:16] == IO_HI) && io_buffer_full;

    case (state_q)
      IDLE: begin
        if (!clear && !inst_ready_q && !data_ready_q && (data_valid || inst_valid)) begin
          is_inst_d = !data_valid;
          addr_d    = acc_addr;
          val_d     = data_value;
          res_d     = '0;
          cnt_d     = 3'd0;
          n_d       = (!data_valid || data_type[1]) ? 3'd4 : (data_type[0] ? 3'd2 : 3'd1);
          if (data_valid && data_wr) begin
            state_d = WR;
            if (!((acc_addr[17:16] == IO_HI) && io_buffer_full)) begin
              mem_a_d    = acc_addr;
              mem_dout_d = data_value[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = RD;
            mem_a_d = acc_addr;
          end
        end
      end
      // cnt_q = k while bus address addr+k is out; byte k-1 arrives on mem_din now
      RD: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          mem_a_d = '0;
        end else begin
          if (cnt_q != 3'd0) res_nxt[{rd_idx[1:0], 3'b000} +: 8] = mem_din;
          res_d = res_nxt;
          if (cnt_q == n_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            mem_a_d = '0;
            if (is_inst_q) begin
              inst_ready_d = 1'b1;
              inst_res_d   = res_nxt;
            end else begin
              data_ready_d = 1'b1;
              data_res_d   = res_nxt;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            mem_a_d = ((cnt_q + 3'd1) < n_q) ? addr_q + ADDR_W'(cnt_q + 3'd1) : '0;
          end
        end
      end
      // cnt_q = bytes already issued; stores are committed, so clear is ignored
      WR: begin
        if (cnt_q == n_q) begin
          state_d      = IDLE;
          cnt_d        = 3'd0;
          mem_a_d      = '0;
          mem_dout_d   = '0;
          mem_wr_d     = 1'b0;
          data_ready_d = 1'b1;
        end else if (io_blk) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = addr_q + ADDR_W'(cnt_q);
          mem_dout_d = val_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      is_inst_q    <= 1'b0;
      addr_q       <= '0;
      val_q        <= '0;
      res_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_res_q   <= '0;
      data_res_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      is_inst_q    <= is_inst_d;
      addr_q       <= addr_d;
      val_q        <= val_d;
      res_q        <= res_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      inst_res_q   <= inst_res_d;
      data_res_q   <= data_res_d;
    end
  end

  // a frozen core must never see a write strobe, even mid-store
  assign mem_wr     = mem_wr_q & rdy;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign inst_ready = inst_ready_q;
  assign inst_res   = inst_res_q;
  assign data_ready = data_ready_q;
  assign data_res   = data_res_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed bus memory, reference
// memory model, directed scenarios then randomized requests.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clear = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid = 1'b0, data_wr = 1'b0;
  logic [2:0]  data_type = '0;
  logic [31:0] data_addr = '0, data_value = '0;
  logic        data_ready;
  logic [31:0] data_res;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_res(inst_res),
    .data_valid(data_valid), .data_wr(data_wr), .data_type(data_type), .data_addr(data_addr),
    .data_value(data_value), .data_ready(data_ready), .data_res(data_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  logic [7:0]  bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] wq[$];
  logic [31:0] raq[$];
  bit          rec = 1'b0;
  int          nvec = 0, nerr = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // external byte memory: data one cycle after address, frozen with rdy
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) bus_mem[mem_a] = mem_dout;
      mem_din <= bus_rd(mem_a);
    end
  end

  always @(posedge clk) begin
    if (rec && rdy) begin
      if (mem_wr) wq.push_back({mem_a, mem_dout});
      else if (mem_a != 32'h0) raq.push_back(mem_a);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    bus_mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic run_req(input bit use_inst, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] v,
                         input int frz_at, input int frz_len, input int stall,
                         input int clr_at, input bit chk_a, input string tag);
    int n, exp_cyc, cyc, lim;
    bit got, abort;
    logic [31:0] exp_res;
    n       = use_inst ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    abort   = !wr && (clr_at > 0);
    exp_res = '0;
    for (int k = 0; k < n; k++) begin
      if (wr) ref_mem[a + 32'(k)] = v[8*k +: 8];
      else    exp_res[8*k +: 8]   = ref_rd(a + 32'(k));
    end
    exp_cyc = (wr ? n + 1 : n + 2) + frz_len + ((wr && a[17:16] == 2'b11) ? stall : 0);
    wq.delete(); raq.delete(); rec = 1'b1;
    @(negedge clk);
    if (use_inst) begin
      inst_valid = 1'b1; inst_addr = a;
    end else begin
      data_valid = 1'b1; data_wr = wr; data_addr = a; data_value = v;
      data_type  = {1'($urandom_range(0, 1)), sz};
    end
    if (stall > 0) io_buffer_full = 1'b1;
    cyc = 0; got = 1'b0; lim = abort ? 12 : 40;
    while (cyc < lim && !got) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (!rdy) chk({tag, " wr_masked"}, 32'(mem_wr), 32'h0);
      if (abort && cyc == clr_at + 1) chk({tag, " abort_idle_a"}, mem_a, 32'h0);
      if (use_inst ? inst_ready : data_ready) begin
        got = 1'b1;
        chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        if (!wr) chk({tag, " result"}, use_inst ? inst_res : data_res, exp_res);
      end
      clear = (cyc == clr_at);
      if (abort && cyc == clr_at) begin inst_valid = 1'b0; data_valid = 1'b0; end
      if (stall > 0 && cyc == stall) io_buffer_full = 1'b0;
      if (frz_len > 0 && cyc == frz_at) rdy = 1'b0;
      if (frz_len > 0 && cyc == frz_at + frz_len) rdy = 1'b1;
    end
    inst_valid = 1'b0; data_valid = 1'b0; clear = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    if (abort) chk({tag, " no_ready"}, 32'(got), 32'h0);
    else       chk({tag, " ready_seen"}, 32'(got), 32'h1);
    @(negedge clk);
    if (got) chk({tag, " single_pulse"}, 32'(use_inst ? inst_ready : data_ready), 32'h0);
    rec = 1'b0;
    if (wr) begin
      chk({tag, " n_writes"}, 32'(wq.size()), 32'(n));
      for (int k = 0; k < n && k < wq.size(); k++) begin
        chk({tag, " wr_addr"}, wq[k][39:8], a + 32'(k));
        chk({tag, " wr_data"}, 32'(wq[k][7:0]), 32'(v[8*k +: 8]));
      end
      for (int k = -1; k <= n; k++)
        chk({tag, " mem_byte"}, 32'(bus_rd(a + 32'(k))), 32'(ref_rd(a + 32'(k))));
    end else if (chk_a && !abort) begin
      chk({tag, " n_reads"}, 32'(raq.size()), 32'(n));
      for (int k = 0; k < n && k < raq.size(); k++)
        chk({tag, " rd_addr"}, raq[k], a + 32'(k));
    end
  endtask

  initial begin
    int cyc;
    bit iseen;
    logic [31:0] exp_i;

    // reset state
    #2;
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", 32'(mem_wr), 32'h0);
    chk("rst mem_dout", 32'(mem_dout), 32'h0);
    chk("rst inst_ready", 32'(inst_ready), 32'h0);
    chk("rst data_ready", 32'(data_ready), 32'h0);
    chk("rst inst_res", inst_res, 32'h0);
    chk("rst data_res", data_res, 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk);

    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h400, 8'h9F);
    for (int k = 0; k < 4; k++) poke(32'h2000 + 32'(k), 8'($urandom));

    run_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 0, 0, 1'b1, "fetch");
    chk("fetch literal", inst_res, 32'h00000513);
    run_req(1'b0, 1'b1, 2'd1, 32'h2001, 32'hA1B2C3D4, 0, 0, 0, 0, 1'b0, "half_st");
    run_req(1'b0, 1'b0, 2'd1, 32'h2001, 32'h0, 0, 0, 0, 0, 1'b1, "half_ld");

    // arbitration: data first, inst after the data_ready cycle
    exp_i = {ref_rd(32'h503), ref_rd(32'h502), ref_rd(32'h501), ref_rd(32'h500)};
    wq.delete(); raq.delete(); rec = 1'b1;
    @(negedge clk);
    data_valid = 1'b1; data_wr = 1'b0; data_type = 3'd0; data_addr = 32'h400;
    inst_valid = 1'b1; inst_addr = 32'h500;
    cyc = 0; iseen = 1'b0;
    while (cyc < 30 && !iseen) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (data_ready) begin
        chk("arb data latency", 32'(cyc), 32'd3);
        chk("arb data_res", data_res, 32'h0000009F);
        data_valid = 1'b0;
      end
      if (inst_ready) begin
        chk("arb inst latency", 32'(cyc), 32'd10);
        chk("arb inst_res", inst_res, exp_i);
        iseen = 1'b1; inst_valid = 1'b0;
      end
    end
    data_valid = 1'b0; inst_valid = 1'b0;
    chk("arb inst seen", 32'(iseen), 32'h1);
    @(negedge clk); rec = 1'b0;
    chk("arb n_addr", 32'(raq.size()), 32'd5);
    if (raq.size() == 5) begin
      chk("arb addr0", raq[0], 32'h400);
      for (int k = 0; k < 4; k++) chk("arb inst addr", raq[k+1], 32'h500 + 32'(k));
    end

    // UART stall on store, and reads at I/O addresses never stall
    run_req(1'b0, 1'b1, 2'd0, 32'h30000, 32'h00000055, 0, 0, 3, 0, 1'b0, "uart_st");
    run_req(1'b0, 1'b1, 2'd2, 32'h30004, 32'h11223344, 0, 0, 2, 0, 1'b0, "uart_wst");
    run_req(1'b0, 1'b0, 2'd2, 32'h30010, 32'h0, 0, 0, 3, 0, 1'b1, "io_rd");

    // flush
    run_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 0, 2, 1'b0, "flush_fetch");
    run_req(1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 0, 0, 0, 4, 1'b0, "flush_ld_last");
    run_req(1'b0, 1'b1, 2'd2, 32'h2100, 32'hCAFEF00D, 0, 0, 0, 2, 1'b0, "flush_st");

    // rdy freeze
    run_req(1'b0, 1'b0, 2'd2, 32'h2100, 32'h0, 2, 2, 0, 0, 1'b1, "frz_ld");
    run_req(1'b0, 1'b1, 2'd2, 32'h2200, 32'h89ABCDEF, 2, 2, 0, 0, 1'b0, "frz_st");

    // address wrap
    run_req(1'b0, 1'b1, 2'd2, 32'hFFFFFFFE, 32'h0BADBEEF, 0, 0, 0, 0, 1'b0, "wrap_st");
    run_req(1'b0, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 0, 1'b0, "wrap_ld");

    // async reset in the middle of a word store
    @(negedge clk);
    data_valid = 1'b1; data_wr = 1'b1; data_type = 3'd2; data_addr = 32'h7000; data_value = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst mem_wr", 32'(mem_wr), 32'h0);
    chk("arst mem_a", mem_a, 32'h0);
    chk("arst mem_dout", 32'(mem_dout), 32'h0);
    chk("arst data_ready", 32'(data_ready), 32'h0);
    chk("arst data_res", data_res, 32'h0);
    chk("arst inst_res", inst_res, 32'h0);
    data_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("arst idle mem_a", mem_a, 32'h0);

    for (int i = 0; i < 25; i++) begin
      bit ui, w;
      logic [1:0] sz;
      logic [31:0] a;
      ui = ($urandom_range(0, 2) == 0);
      w  = ui ? 1'b0 : 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      run_req(ui, w, sz, a, $urandom, 1, $urandom_range(0, 2), 0, 0,
              (a > 32'h10) && (a < 32'hFFFFFFF0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the cache/fetch side and the 8-bit external memory bus of the RISCV32 core.
- Serialises 1/2/4-byte instruction and data requests into byte-wide bus cycles, then reassembles read results.
- Arbitrates the instruction and data ports, stalls UART writes while the TX buffer is full, and honours pipeline flush.
- Sits directly downstream of the cache and drives the cpu pins mem_a, mem_dout and mem_wr.

Parameters:
- ADDR_W, 32, address width of request and bus addresses.
- IO_HI, 2'b11, value of addr[17:16] that marks an I/O access.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes the block
- clear  in  1  ROB flush; aborts speculative reads
- inst_valid  in  1  instruction fetch request (level, held until inst_ready)
- inst_addr  in  32  fetch address (word)
- inst_ready  out  1  one-cycle pulse, inst_res valid
- inst_res  out  32  fetched instruction, little-endian
- data_valid  in  1  data request (level, held until data_ready)
- data_wr  in  1  1 = store, 0 = load
- data_type  in  3  [1:0] size: 0 = byte, 1 = half, 2 = word; [2] reserved, ignored
- data_addr  in  32  data address
- data_value  in  32  store data, low bytes used
- data_ready  out  1  one-cycle pulse, load result valid / store done
- data_res  out  32  load result, zero-extended
- mem_din  in  8  bus read data, valid one cycle after address
- mem_dout  out  8  bus write data
- mem_a  out  32  bus address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; byte counter 0; result register 0.
- rdy low: no state/counter/register changes; mem_wr masked to 0 combinationally. The pending byte is re-driven when rdy returns.
- FSM states: IDLE, RD, WR.
- Registered outputs; edge E0 = accept edge.
- Acceptance happens only in IDLE, and only when inst_ready and data_ready are both low that cycle.
- Port priority: data over inst. The winning port's addr, size and value are latched at E0. N = 1, 2 or 4 bytes; instruction fetch is always N = 4.
- RD: during the cycle after E_k, mem_a = addr + k, for k = 0..N-1. Byte k is captured from mem_din at E_{k+2} into res[8k+7:8k].
  - At E_{N+1}: the port's ready goes high for one cycle with the result; state returns to IDLE; mem_a = 0.
  - Word read: ready is high in the cycle after E5.
- WR: during the cycle after E_k, mem_a = addr + k, mem_dout = value[8k+7:8k], mem_wr = 1, for k = 0..N-1.
  - At E_N: mem_wr = 0, data_ready pulses, state returns to IDLE.
  - Word store: 4 bus writes; data_ready is high in the cycle after E4.
- IO stall: for a write with addr[17:16] == IO_HI, a byte is issued only at an edge where io_buffer_full is low. Otherwise mem_wr = 0 and the counter holds until the buffer drains. Reads never stall.
- Address arithmetic is modulo 2^32. Bytes of a misaligned half/word are issued sequentially with no alignment check.
- clear high at an active edge:
  - Any RD in progress (inst or data load) is aborted: state returns to IDLE and no ready pulse is issued, including one due at that same edge.
  - A WR in progress (committed store) is unaffected and completes.
  - In IDLE, no request is accepted at that edge.
- Simultaneous inst_valid and data_valid in IDLE: data is served first; inst waits.
- rst low mid-transfer: immediate IDLE, outputs 0; the partial transfer is lost.
- Bus is idle between transfers: mem_a = 0, mem_wr = 0, mem_dout = 0.

Test Plan:
- Word fetch: inst_valid, inst_addr = 0x100; memory returns bytes 0x13,0x05,0x00,0x00 -> mem_a = 0x100..0x103 on consecutive cycles; inst_ready is a single pulse 5 cycles after accept with inst_res = 0x00000513.
- Half store: data_wr = 1, data_type = 1, data_addr = 0x2001, data_value = 0xA1B2C3D4 -> two writes, (0x2001, 0xD4) then (0x2002, 0xC3); data_ready 2 cycles after accept; memory bytes 0x2000 and 0x2003 unchanged.
- Arbitration: inst_valid and data_valid (byte load at 0x400 = 0x9F) asserted together -> data served first with data_res = 0x0000009F; inst transfer starts after the data_ready cycle; no overlap on mem_a.
- UART stall: byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles; exactly one write of the byte once the buffer drains, then data_ready.
- Flush: clear pulsed on the 2nd byte of a word fetch -> no inst_ready, IDLE next cycle; clear pulsed during a word store -> all 4 bytes written and data_ready asserted.
- rdy freeze: rdy low for 2 cycles in the middle of a word load -> mem_wr = 0, mem_a held, result identical to the unfrozen run, ready delayed by exactly 2 cycles; async rst low mid-read -> all outputs 0 immediately.
